// File: rtl/scs8hd_o22ai_filt_if.sv
// ---------------------------------------------------------------------------
// scs8hd_o22ai_filt_if
// Bundles the lane-level signals of the filtered OAI22 block.
//
// Signals (all WIDTH bits unless noted):
//   EN         (1 bit) sample enable, driven by the master
//   A1, A2     OR-group A inputs, driven by the master
//   B1, B2     OR-group B inputs, driven by the master
//   Y          filtered OAI22 result, driven by the slave (filter)
//   PEND       per-lane "change pending" flag, driven by the slave
//   CHG        per-lane one-cycle commit pulse, driven by the slave
//              (present only when SCS8HD_O22AI_FILT_CHG_EN is defined)
//
// Modports:
//   master : the logic that drives the inputs and observes the outputs
//   slave  : the filter block itself
// ---------------------------------------------------------------------------
interface scs8hd_o22ai_filt_if #(
    parameter int WIDTH = 4
);
    logic             EN;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] A2;
    logic [WIDTH-1:0] B1;
    logic [WIDTH-1:0] B2;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] PEND;
`ifdef SCS8HD_O22AI_FILT_CHG_EN
    logic [WIDTH-1:0] CHG;
`endif

    modport master (
        output EN,
        output A1,
        output A2,
        output B1,
        output B2,
`ifdef SCS8HD_O22AI_FILT_CHG_EN
        input  CHG,
`endif
        input  Y,
        input  PEND
    );

    modport slave (
        input  EN,
        input  A1,
        input  A2,
        input  B1,
        input  B2,
`ifdef SCS8HD_O22AI_FILT_CHG_EN
        output CHG,
`endif
        output Y,
        output PEND
    );
endinterface

// File: rtl/scs8hd_o22ai_filt.sv
// ---------------------------------------------------------------------------
// scs8hd_o22ai_filt
// WIDTH independent OAI22 lanes, Y = !((A1|A2)&(B1|B2)), each followed by a
// digital deglitch filter. A lane's Y only takes a new value once the raw
// OAI22 result has differed from Y for FILT_CYCLES consecutive enabled clocks.
//
// Ports:
//   CLK     rising-edge clock
//   RESETB  asynchronous active-low reset
//   bus     scs8hd_o22ai_filt_if.slave: EN, A1, A2, B1, B2 in; Y, PEND out
//           (plus CHG out when the optional macro is defined)
//
// Parameters:
//   WIDTH        number of lanes (>= 1)
//   FILT_CYCLES  consecutive enabled samples needed to commit (1..15)
//   RESET_Y      value loaded into every Y bit on reset
//
// Optional feature macro: SCS8HD_O22AI_FILT_CHG_EN
//   When defined, CHG[i] pulses high for the one cycle after an edge that
//   committed a new Y[i]. When undefined, CHG and its flops do not exist.
// ---------------------------------------------------------------------------
module scs8hd_o22ai_filt #(
    parameter int   WIDTH       = 4,
    parameter int   FILT_CYCLES = 3,
    parameter logic RESET_Y     = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RESETB,
    scs8hd_o22ai_filt_if.slave      bus
);

    // Counter only needs to reach FILT_CYCLES-1; the +1 keeps CW >= 1 even
    // when FILT_CYCLES is 1 (counter then stays at zero permanently).
    localparam int             CW      = $clog2(FILT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_CYCLES - 1);

    logic [WIDTH-1:0] y_vec;
    logic [WIDTH-1:0] pend_vec;
`ifdef SCS8HD_O22AI_FILT_CHG_EN
    logic [WIDTH-1:0] commit_vec;
    logic [WIDTH-1:0] chg_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            logic          raw;
            logic          y_reg;
            logic          y_next;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;

            assign raw = ~((bus.A1[gi] | bus.A2[gi]) & (bus.B1[gi] | bus.B2[gi]));

            // raw matching Y wipes any partial run, so a glitch shorter than
            // FILT_CYCLES leaves no trace. With EN low nothing moves.
            always_comb begin
                y_next   = y_reg;
                cnt_next = cnt_reg;
                if (bus.EN) begin
                    if (raw == y_reg) begin
                        cnt_next = '0;
                    end else if (cnt_reg == CNT_MAX) begin
                        y_next   = raw;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end

            always_ff @(posedge CLK or negedge RESETB) begin
                if (!RESETB) begin
                    y_reg   <= RESET_Y;
                    cnt_reg <= '0;
                end else begin
                    y_reg   <= y_next;
                    cnt_reg <= cnt_next;
                end
            end

            assign y_vec[gi]    = y_reg;
            assign pend_vec[gi] = (cnt_reg != '0);
`ifdef SCS8HD_O22AI_FILT_CHG_EN
            // A commit is the only way Y can change on an edge.
            assign commit_vec[gi] = (y_next != y_reg);
`endif
        end
    endgenerate

`ifdef SCS8HD_O22AI_FILT_CHG_EN
    // commit_vec is zero whenever EN is low, so CHG self-clears on that edge.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            chg_reg <= '0;
        end else begin
            chg_reg <= commit_vec;
        end
    end

    assign bus.CHG = chg_reg;
`endif

    assign bus.Y    = y_vec;
    assign bus.PEND = pend_vec;

endmodule

// File: tb/tb_scs8hd_o22ai_filt.sv
// ---------------------------------------------------------------------------
// tb_scs8hd_o22ai_filt
// Directed bench for scs8hd_o22ai_filt. dut0 uses WIDTH=4, FILT_CYCLES=3 and
// is driven from a table of {EN, A1, A2, B1, B2, expected Y/PEND/CHG}
// records; the async reset and the FILT_CYCLES=1 instance (dut1) are
// exercised by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_scs8hd_o22ai_filt;

    logic CLK;
    logic RESETB;

    int n_vec;
    int n_fail;

    scs8hd_o22ai_filt_if #(.WIDTH(4)) bus0 ();
    scs8hd_o22ai_filt_if #(.WIDTH(4)) bus1 ();

    scs8hd_o22ai_filt #(.WIDTH(4), .FILT_CYCLES(3), .RESET_Y(1'b1)) dut0 (
        .CLK    (CLK),
        .RESETB (RESETB),
        .bus    (bus0)
    );

    scs8hd_o22ai_filt #(.WIDTH(4), .FILT_CYCLES(1), .RESET_Y(1'b1)) dut1 (
        .CLK    (CLK),
        .RESETB (RESETB),
        .bus    (bus1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       en;
        logic [3:0] a1;
        logic [3:0] a2;
        logic [3:0] b1;
        logic [3:0] b2;
        logic [3:0] y;
        logic [3:0] pend;
        logic [3:0] chg;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] b1, input logic [3:0] b2,
                       input logic [3:0] y, input logic [3:0] pend, input logic [3:0] chg);
        vec_t v;
        v.en = en; v.a1 = a1; v.a2 = a2; v.b1 = b1; v.b2 = b2;
        v.y = y; v.pend = pend; v.chg = chg;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic check0(input string nm, input logic [3:0] y, input logic [3:0] pend,
                          input logic [3:0] chg);
        cmp({nm, " Y"}, bus0.Y, y);
        cmp({nm, " PEND"}, bus0.PEND, pend);
`ifdef SCS8HD_O22AI_FILT_CHG_EN
        cmp({nm, " CHG"}, bus0.CHG, chg);
`else
        if (chg === 4'bxxxx) $display("unreachable");
`endif
        $display("%0t %s: Y=%h PEND=%h", $time, nm, bus0.Y, bus0.PEND);
    endtask

    // Drive dut0 inputs, take one rising edge, sample 1 time unit later.
    task automatic step0(input string nm, input logic en, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] b1, input logic [3:0] b2,
                         input logic [3:0] y, input logic [3:0] pend, input logic [3:0] chg);
        bus0.EN = en; bus0.A1 = a1; bus0.A2 = a2; bus0.B1 = b1; bus0.B2 = b2;
        @(posedge CLK);
        #1;
        check0(nm, y, pend, chg);
    endtask

    logic [3:0] b2_pat [8];

    initial begin
        n_vec  = 0;
        n_fail = 0;

        // ---------------- vector table for dut0 (FILT_CYCLES=3) ----------------
        // all inputs high: raw=0, commit on 3rd edge
        add(1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        add(1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        add(1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF);
        // back to all-low: raw=F
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF);
        // lane0 two-edge glitch is forgotten
        add(1, 4'h1, 4'h0, 4'h1, 4'h0, 4'hF, 4'h1, 4'h0);
        add(1, 4'h1, 4'h0, 4'h1, 4'h0, 4'hF, 4'h1, 4'h0);
        add(1, 4'h1, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
        // lane1: A1 drops while A2 holds raw constant -> run continues
        add(1, 4'h2, 4'h2, 4'h2, 4'h0, 4'hF, 4'h2, 4'h0);
        add(1, 4'h0, 4'h2, 4'h2, 4'h0, 4'hF, 4'h2, 4'h0);
        add(1, 4'h0, 4'h2, 4'h2, 4'h0, 4'hD, 4'h0, 4'h2);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hD, 4'h2, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hD, 4'h2, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h2);
        // lane2: one enabled edge, 5 disabled edges (inputs chatter), then 2 more
        add(1, 4'h4, 4'h0, 4'h0, 4'h4, 4'hF, 4'h4, 4'h0);
        for (int i = 0; i < 5; i++)
            add(0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h4, 4'h0);
        add(1, 4'h4, 4'h0, 4'h0, 4'h4, 4'hF, 4'h4, 4'h0);
        add(1, 4'h4, 4'h0, 4'h0, 4'h4, 4'hB, 4'h0, 4'h4);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h4, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB, 4'h4, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h4);
        // lanes 1 and 3 commit on the same edge
        add(1, 4'h8, 4'h2, 4'h8, 4'h2, 4'hF, 4'hA, 4'h0);
        add(1, 4'h8, 4'h2, 4'h8, 4'h2, 4'hF, 4'hA, 4'h0);
        add(1, 4'h8, 4'h2, 4'h8, 4'h2, 4'h5, 4'h0, 4'hA);
        add(1, 4'h8, 4'h2, 4'h8, 4'h2, 4'h5, 4'h0, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'hA, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'hA, 4'h0);
        add(1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'hA);
        // EN low right after a commit: CHG clears, state holds
        add(0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0);

        // ---------------- reset ----------------
        RESETB  = 1'b0;
        bus0.EN = 1'b1;
        bus0.A1 = 4'hF; bus0.A2 = 4'hF; bus0.B1 = 4'hF; bus0.B2 = 4'hF;
        bus1.EN = 1'b1;
        bus1.A1 = 4'h0; bus1.A2 = 4'h0; bus1.B1 = 4'h0; bus1.B2 = 4'h0;
        repeat (2) @(posedge CLK);
        #1;
        RESETB = 1'b1;
        #1;
        check0("reset", 4'hF, 4'h0, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            step0(nm, vecs[i].en, vecs[i].a1, vecs[i].a2, vecs[i].b1, vecs[i].b2,
                  vecs[i].y, vecs[i].pend, vecs[i].chg);
        end

        // ---------------- async reset mid-count ----------------
        step0("pre_rst1", 1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        step0("pre_rst2", 1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        #3;
        RESETB = 1'b0;
        #1;
        check0("async_rst", 4'hF, 4'h0, 4'h0);
        @(posedge CLK);
        #1;
        check0("rst_held", 4'hF, 4'h0, 4'h0);
        RESETB = 1'b1;
        step0("post_rst1", 1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        step0("post_rst2", 1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0);
        step0("post_rst3", 1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF);

        // ---------------- FILT_CYCLES=1 instance ----------------
        // A1=F, A2=0, B1=0 makes raw = ~B2, so Y after each edge is ~B2.
        b2_pat[0] = 4'h1; b2_pat[1] = 4'h3; b2_pat[2] = 4'h0; b2_pat[3] = 4'hF;
        b2_pat[4] = 4'h5; b2_pat[5] = 4'hA; b2_pat[6] = 4'h6; b2_pat[7] = 4'h0;
        for (int i = 0; i < 8; i++) begin
            bus1.EN = 1'b1;
            bus1.A1 = 4'hF; bus1.A2 = 4'h0; bus1.B1 = 4'h0; bus1.B2 = b2_pat[i];
            @(posedge CLK);
            #1;
            cmp($sformatf("fc1_%0d Y", i), bus1.Y, ~b2_pat[i]);
            cmp($sformatf("fc1_%0d PEND", i), bus1.PEND, 4'h0);
            $display("%0t fc1_%0d: B2=%h Y=%h PEND=%h", $time, i, b2_pat[i], bus1.Y, bus1.PEND);
        end
        // EN low on the FILT_CYCLES=1 instance: Y holds last value (~0 = F)
        bus1.EN = 1'b0;
        bus1.B2 = 4'hF;
        @(posedge CLK);
        #1;
        cmp("fc1_hold Y", bus1.Y, 4'hF);
        $display("%0t fc1_hold: Y=%h", $time, bus1.Y);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/scs8hd_o22ai_filt.md
Name: scs8hd_o22ai_filt

Overview:
Parametrised, clocked successor to the single-bit OAI22 cell.
- WIDTH independent lanes, each computing Y = !((A1|A2)&(B1|B2)).
- Each lane's output passes through a per-lane digital deglitch filter: Y changes only after the new combinational value persists for FILT_CYCLES consecutive enabled clocks.
- Used at slow control/status boundaries inside scs8hd-based macros where input chatter must not propagate.

Parameters:
- WIDTH, 4: number of independent OAI22 lanes (>=1).
- FILT_CYCLES, 3: consecutive enabled samples required to commit a change (legal range 1..15).
- RESET_Y, 1'b1: value loaded into every Y bit on reset (1 matches all-inputs-low OAI22 output).

Ports:
- CLK  input  1  rising-edge clock.
- RESETB  input  1  asynchronous active-low reset.
- EN  input  1  sample enable; when low, all state holds.
- A1  input  WIDTH  OR-group A input 1, per lane.
- A2  input  WIDTH  OR-group A input 2, per lane.
- B1  input  WIDTH  OR-group B input 1, per lane.
- B2  input  WIDTH  OR-group B input 2, per lane.
- Y  output  WIDTH  filtered, registered OAI22 result.
- PEND  output  WIDTH  lane has a pending (uncommitted) change; PEND[i] = (cnt[i] != 0).

Behaviour:
- Per lane i: raw[i] = ~((A1[i]|A2[i]) & (B1[i]|B2[i])). This is combinational only and internal.
- Counter cnt[i] is CW = $clog2(FILT_CYCLES+1) bits wide, unsigned, and never exceeds FILT_CYCLES-1.
- Reset (RESETB low, asynchronous assert, synchronous-to-CLK deassert handled externally):
  - Y = {WIDTH{RESET_Y}}.
  - All cnt = 0, so PEND = 0.
  - Reset mid-count discards partial progress.
- Rising CLK edge with EN=1, per lane:
  - raw == Y: cnt <= 0. A glitch shorter than FILT_CYCLES is fully forgotten.
  - raw != Y and cnt == FILT_CYCLES-1: Y <= raw, cnt <= 0.
  - raw != Y otherwise: cnt <= cnt+1.
- Rising CLK edge with EN=0: Y and cnt hold, regardless of inputs.
- Latency:
  - Y changes on the FILT_CYCLES-th consecutive enabled edge at which raw differs from Y.
  - FILT_CYCLES=1 degenerates to a plain enabled register: Y follows raw one edge later, and PEND is always 0.
- Counting is per lane, with no cross-lane coupling. Simultaneous commits on several lanes are permitted.
- Input changes that keep raw constant (e.g. A1 0->1 while A2=1) do not affect cnt.
- No lane-state FSM beyond Y/cnt. Lane state is the pair (Y, cnt): IDLE (cnt=0), PENDING (cnt>0), and COMMIT is the transition out of PENDING.
- EN gaps inside a pending run neither reset nor advance cnt.

Optional Feature:
- Macro: SCS8HD_O22AI_FILT_CHG_EN.
- Defined:
  - Adds output port CHG [WIDTH-1:0], registered, reset 0.
  - CHG[i] is 1 in exactly the cycle following an edge that committed a new Y[i]; otherwise 0.
  - With EN=0, CHG clears on the next edge.
- Undefined:
  - Port CHG and its flops are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=4, FILT_CYCLES=3. RESETB low with A1=A2=B1=B2=4'hF, then release -> Y=4'hF, PEND=0. On the 3rd enabled edge Y=4'h0; PEND=4'hF after edges 1–2.
- Lane0 A1=1, B1=1 for 2 edges, then B1=0 -> PEND[0] rises then clears, Y[0] stays 1. No CHG pulse (macro on).
- Lane2 target change held 3 edges with EN=0 inserted after edge 1 for 5 cycles -> Y[2] commits on the 3rd enabled edge, not before.
- Assert RESETB low asynchronously with cnt=2 on all lanes -> Y=4'hF and PEND=0 immediately without a clock. After release, a fresh 3-edge run is needed.
- FILT_CYCLES=1 build: toggle B2 patterns every cycle -> Y equals the previous cycle's raw, PEND always 0.
- Macro defined, lanes 1 and 3 commit on the same edge -> CHG=4'b1010 for exactly one cycle, then 4'b0000.
